rs_alu: RTL and testbench

ALU reservation station sitting directly downstream of the ID/EX pipeline register and upstream of the ALU execution unit. It captures ALU-class instructions dispatched from ID/EX, holds them until both source operands are available, snoops the common data bus (CDB) to wake waiting operands, and issues the oldest ready entry to the ALU under a valid/ready handshake. A flush input discards all held work on branch mispredict.

---
 rtl/rs_alu_pkg.sv | 53 +++++
 rtl/rs_alu_if.sv | 46 ++++
 rtl/rs_alu_select.sv | 26 ++
 rtl/rs_alu.sv | 127 ++++++++++++
 tb/tb_rs_alu.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_alu_pkg.sv
// Shared definitions for the ALU reservation station:
// unit encoding, widths, entry layout and CDB match helper.
package rs_alu_pkg;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;
    localparam int UNIT_W = 3;

    localparam logic [UNIT_W-1:0] UNIT_ALU = 3'd1;
    localparam logic [TAG_W-1:0]  TAG_NONE = '0;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  val1;
        logic [TAG_W-1:0] tag1;
        logic [XLEN-1:0]  val2;
        logic [TAG_W-1:0] tag2;
        logic [TAG_W-1:0] target;
        logic [XLEN-1:0]  pc;
    } rs_entry_t;

    // Tag 0 means "no producer" and therefore never matches the CDB.
    function automatic logic cdb_hit(
        input logic [TAG_W-1:0] tag,
        input logic             cv,
        input logic [TAG_W-1:0] ct
    );
        return cv && (tag != TAG_NONE) && (tag == ct);
    endfunction

    // Capture a CDB broadcast into any operand waiting on that tag.
    function automatic rs_entry_t wake(
        input rs_entry_t        e,
        input logic             cv,
        input logic [TAG_W-1:0] ct,
        input logic [XLEN-1:0]  cval
    );
        rs_entry_t r;
        r = e;
        if (cdb_hit(e.tag1, cv, ct)) begin
            r.val1 = cval;
            r.tag1 = TAG_NONE;
        end
        if (cdb_hit(e.tag2, cv, ct)) begin
            r.val2 = cval;
            r.tag2 = TAG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_alu_if.sv
// Dispatch, CDB and ALU-issue signals of the ALU reservation station.
// master = environment side, slave = reservation station side.
interface rs_alu_if;
    import rs_alu_pkg::*;

    logic              flush;
    logic              in_valid;
    logic [UNIT_W-1:0] in_unit;
    logic [OP_W-1:0]   in_op;
    logic [XLEN-1:0]   in_val1;
    logic [XLEN-1:0]   in_val2;
    logic [TAG_W-1:0]  in_tag1;
    logic [TAG_W-1:0]  in_tag2;
    logic [TAG_W-1:0]  in_target;
    logic [XLEN-1:0]   in_pc;
    logic              in_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [XLEN-1:0]   cdb_val;
    logic              alu_valid;
    logic              alu_ready;
    logic [OP_W-1:0]   alu_op;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [TAG_W-1:0]  alu_target;
    logic [XLEN-1:0]   alu_pc;

    modport master (
        output flush, in_valid, in_unit, in_op,
        output in_val1, in_val2, in_tag1, in_tag2,
        output in_target, in_pc,
        output cdb_valid, cdb_tag, cdb_val, alu_ready,
        input  in_ready, alu_valid, alu_op,
        input  alu_a, alu_b, alu_target, alu_pc
    );

    modport slave (
        input  flush, in_valid, in_unit, in_op,
        input  in_val1, in_val2, in_tag1, in_tag2,
        input  in_target, in_pc,
        input  cdb_valid, cdb_tag, cdb_val, alu_ready,
        output in_ready, alu_valid, alu_op,
        output alu_a, alu_b, alu_target, alu_pc
    );

endinterface

// File: rtl/rs_alu_select.sv
// Lowest-index priority picker: one-hot grant of the
// oldest requesting entry plus an any-request flag.
module rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_grant,
    output logic             o_any
);

    assign o_any = |i_req;

    // First set bit from index 0 upward wins.
    always_comb begin
        logic w_found;
        w_found = 1'b0;
        o_grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_req[i] && !w_found) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: compacting age-ordered queue that
// wakes operands from the CDB and issues the oldest ready entry.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    rs_alu_if.slave  io_bus
);

    localparam int CW = $clog2(DEPTH + 1);

    rs_entry_t        r_q [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_grant;
    logic             w_any;
    rs_entry_t        w_sel;
    logic             w_in_ready;
    logic             w_alu_valid;
    logic             w_fire;
    logic             w_alloc;
    rs_entry_t        w_new;
    rs_entry_t        w_ext [DEPTH+1];
    rs_entry_t        w_nq  [DEPTH];
    logic [CW-1:0]    w_wr_idx;
    logic [CW-1:0]    w_count_n;

    // Readiness comes only from registered entry state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = r_q[i].valid
                    && (r_q[i].tag1 == TAG_NONE)
                    && (r_q[i].tag2 == TAG_NONE);
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_sel (
        .i_req   (w_rdy),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // Mux out the granted entry; all-zero when nothing is ready.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel = r_q[i];
            end
        end
    end

    assign w_in_ready  = (r_count != CW'(DEPTH));
    assign w_alu_valid = w_any && !io_bus.flush;
    assign w_fire      = w_alu_valid && io_bus.alu_ready;
    assign w_alloc     = io_bus.in_valid
                      && (io_bus.in_unit == UNIT_ALU)
                      && w_in_ready
                      && !io_bus.flush;

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.alu_valid  = w_alu_valid;
    assign io_bus.alu_op     = w_sel.op;
    assign io_bus.alu_a      = w_sel.val1;
    assign io_bus.alu_b      = w_sel.val2;
    assign io_bus.alu_target = w_sel.target;
    assign io_bus.alu_pc     = w_sel.pc;

    // Next queue image: shift out the issued entry, wake operands,
    // then append the new instruction behind the survivors.
    always_comb begin
        logic w_seen;
        w_new.valid  = 1'b1;
        w_new.op     = io_bus.in_op;
        w_new.val1   = io_bus.in_val1;
        w_new.tag1   = io_bus.in_tag1;
        w_new.val2   = io_bus.in_val2;
        w_new.tag2   = io_bus.in_tag2;
        w_new.target = io_bus.in_target;
        w_new.pc     = io_bus.in_pc;
        w_new = wake(w_new, io_bus.cdb_valid,
                     io_bus.cdb_tag, io_bus.cdb_val);

        w_wr_idx  = r_count - CW'(w_fire);
        w_count_n = r_count + CW'(w_alloc) - CW'(w_fire);

        for (int i = 0; i < DEPTH; i++) begin
            w_ext[i] = r_q[i];
        end
        w_ext[DEPTH] = '0;

        w_seen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_seen = w_seen | w_grant[i];
            if (w_fire && w_seen) begin
                w_nq[i] = w_ext[i+1];
            end else begin
                w_nq[i] = w_ext[i];
            end
            w_nq[i] = wake(w_nq[i], io_bus.cdb_valid,
                           io_bus.cdb_tag, io_bus.cdb_val);
            if (w_alloc && (CW'(i) == w_wr_idx)) begin
                w_nq[i] = w_new;
            end
        end
    end

    // Queue and occupancy registers; reset and flush both empty it.
    always_ff @(posedge clk) begin
        if (rst || io_bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_nq[i];
            end
            r_count <= w_count_n;
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: a queue-level model predicts each
// cycle's outputs; a monitor pops and compares against the DUT.
module tb_rs_alu;
    import rs_alu_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_alu_if bus ();

    rs_alu #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  v1, v2, pc;
        logic [TAG_W-1:0] t1, t2, tg;
    } m_ent_t;

    typedef struct {
        bit               valid;
        bit               rdy;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  a, b, pc;
        logic [TAG_W-1:0] tgt;
    } exp_t;

    typedef struct {
        bit                fl, iv, cv, ar;
        logic [UNIT_W-1:0] un;
        logic [OP_W-1:0]   op;
        logic [XLEN-1:0]   v1, v2, pc, cval;
        logic [TAG_W-1:0]  t1, t2, tg, ct;
    } stim_t;

    m_ent_t mq[$];
    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     mon_on = 0;
    int     pcn = 0;

    task automatic chk(input string nm,
                       input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.fl = 0; s.iv = 0; s.cv = 0; s.ar = 1;
        s.un = UNIT_ALU; s.op = '0;
        s.v1 = '0; s.v2 = '0; s.pc = '0; s.cval = '0;
        s.t1 = '0; s.t2 = '0; s.tg = '0; s.ct = '0;
        return s;
    endfunction

    function automatic stim_t disp(input logic [OP_W-1:0] op,
                                   input logic [XLEN-1:0] v1,
                                   input logic [TAG_W-1:0] t1,
                                   input logic [XLEN-1:0] v2,
                                   input logic [TAG_W-1:0] t2);
        stim_t s;
        s = idle();
        s.iv = 1; s.op = op;
        s.v1 = v1; s.t1 = t1; s.v2 = v2; s.t2 = t2;
        s.tg = TAG_W'(op);
        s.pc = 32'h1000 + 32'(pcn * 4);
        pcn++;
        return s;
    endfunction

    // Drive one cycle and push the model's prediction for it.
    task automatic tick(input stim_t s);
        exp_t   e;
        m_ent_t n;
        int     idx;
        @(negedge clk);
        bus.flush     = s.fl;
        bus.in_valid  = s.iv;
        bus.in_unit   = s.un;
        bus.in_op     = s.op;
        bus.in_val1   = s.v1;
        bus.in_val2   = s.v2;
        bus.in_tag1   = s.t1;
        bus.in_tag2   = s.t2;
        bus.in_target = s.tg;
        bus.in_pc     = s.pc;
        bus.cdb_valid = s.cv;
        bus.cdb_tag   = s.ct;
        bus.cdb_val   = s.cval;
        bus.alu_ready = s.ar;
        #2;
        idx = -1;
        foreach (mq[i]) begin
            if (idx < 0 && mq[i].t1 == 0 && mq[i].t2 == 0) idx = i;
        end
        e = '{default: '0};
        e.rdy   = (mq.size() != DEPTH);
        e.valid = (idx >= 0) && !s.fl;
        if (e.valid) begin
            e.op  = mq[idx].op;
            e.a   = mq[idx].v1;
            e.b   = mq[idx].v2;
            e.tgt = mq[idx].tg;
            e.pc  = mq[idx].pc;
        end
        sb.push_back(e);
        if (s.fl) begin
            mq.delete();
        end else begin
            if (e.valid && s.ar) mq.delete(idx);
            foreach (mq[i]) begin
                if (s.cv && s.ct != 0 && mq[i].t1 == s.ct) begin
                    mq[i].v1 = s.cval; mq[i].t1 = 0;
                end
                if (s.cv && s.ct != 0 && mq[i].t2 == s.ct) begin
                    mq[i].v2 = s.cval; mq[i].t2 = 0;
                end
            end
            if (s.iv && s.un == UNIT_ALU && e.rdy) begin
                n.op = s.op; n.tg = s.tg; n.pc = s.pc;
                n.v1 = s.v1; n.t1 = s.t1;
                n.v2 = s.v2; n.t2 = s.t2;
                if (s.cv && s.ct != 0 && s.t1 == s.ct) begin
                    n.v1 = s.cval; n.t1 = 0;
                end
                if (s.cv && s.ct != 0 && s.t2 == s.ct) begin
                    n.v2 = s.cval; n.t2 = 0;
                end
                mq.push_back(n);
            end
        end
    endtask

    // Monitor: one prediction per cycle, checked before the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_on && sb.size() > 0) begin
                e = sb.pop_front();
                chk("in_ready", bus.in_ready, e.rdy);
                chk("alu_valid", bus.alu_valid, e.valid);
                if (e.valid) begin
                    chk("alu_op", bus.alu_op, e.op);
                    chk("alu_a", bus.alu_a, e.a);
                    chk("alu_b", bus.alu_b, e.b);
                    chk("alu_target", bus.alu_target, e.tgt);
                    chk("alu_pc", bus.alu_pc, e.pc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        bus.flush = 0; bus.in_valid = 0; bus.in_unit = '0;
        bus.in_op = '0; bus.in_val1 = '0; bus.in_val2 = '0;
        bus.in_tag1 = '0; bus.in_tag2 = '0; bus.in_target = '0;
        bus.in_pc = '0; bus.cdb_valid = 0; bus.cdb_tag = '0;
        bus.cdb_val = '0; bus.alu_ready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #4;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_alu_valid", bus.alu_valid, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_target", bus.alu_target, 0);
        chk("rst_alu_pc", bus.alu_pc, 0);
        mon_on = 1;

        // Ready-at-dispatch ADD issues the next cycle.
        tick(disp(6'd1, 32'd5, 0, 32'd7, 0));
        tick(idle());
        tick(idle());

        // Operand 1 woken by a later CDB broadcast.
        tick(disp(6'd2, 32'hdead, 4'd3, 32'd1, 0));
        s = idle(); s.cv = 1; s.ct = 4'd3; s.cval = 32'h10;
        tick(s);
        tick(idle());
        tick(idle());

        // Allocation-time bypass on operand 2.
        s = disp(6'd3, 32'd4, 0, 32'hbeef, 4'd5);
        s.cv = 1; s.ct = 4'd5; s.cval = 32'd9;
        tick(s);
        tick(idle());
        tick(idle());

        // Fill with ALU stalled, overflow dropped, fire+alloc.
        for (int i = 0; i < 5; i++) begin
            s = disp(6'(10 + i), 32'(i), 0, 32'(i * 3), 0);
            s.ar = 0;
            tick(s);
        end
        tick(disp(6'd20, 32'd77, 0, 32'd88, 0));
        for (int i = 0; i < 6; i++) tick(idle());

        // Younger ready entry bypasses older waiting one.
        tick(disp(6'd30, 32'h0, 4'd2, 32'd1, 0));
        s = disp(6'd31, 32'd2, 0, 32'd3, 0); s.ar = 0;
        tick(s);
        tick(idle());
        s = idle(); s.cv = 1; s.ct = 4'd2; s.cval = 32'h22;
        tick(s);
        tick(idle());
        tick(idle());

        // Flush with held entries and a concurrent dispatch.
        for (int i = 0; i < 3; i++) tick(disp(6'(40 + i), 0, 4'd7, 0, 0));
        s = disp(6'd50, 32'd1, 0, 32'd1, 0); s.fl = 1;
        tick(s);
        tick(idle());
        for (int i = 0; i < 3; i++) begin
            s = disp(6'd51, 32'd1, 0, 32'd1, 0);
            s.un = 3'(2 + i);
            tick(s);
        end
        tick(idle());

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            s = idle();
            if ($urandom_range(0, 9) < 6) begin
                s = disp(6'($urandom), $urandom,
                         ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
                         $urandom,
                         ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0);
                if ($urandom_range(0, 9) == 0) s.un = 3'($urandom);
            end
            s.cv   = $urandom_range(0, 1) == 1;
            s.ct   = 4'($urandom_range(0, 7));
            s.cval = $urandom;
            s.ar   = $urandom_range(0, 9) < 7;
            s.fl   = $urandom_range(0, 99) < 2;
            tick(s);
        end

        // Drain by broadcasting every tag, then flush to idle.
        for (int c = 0; c < 40; c++) begin
            s = idle(); s.cv = 1;
            s.ct = 4'((c % 15) + 1); s.cval = 32'(c);
            tick(s);
        end
        s = idle(); s.fl = 1;
        tick(s);
        tick(idle());
        tick(idle());
        @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
